// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
//   Main control unit of the multi-cycle MIPS core. Steps every instruction
//   through fetch, decode, execute, memory and writeback states and drives
//   the datapath enables and mux selects for each step.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset (state -> FETCH at once)
//   op[5:0]   in   opcode instr[31:26] from the instruction register
//   zero      in   ALU zero flag
//   pcwrite   out  unconditional PC write
//   branch    out  conditional branch qualifier
//   pcen      out  PC enable = pcwrite | (branch & zero), combinational
//   iord      out  memory address select: 0 = PC, 1 = ALUOut
//   memwrite  out  memory write strobe
//   irwrite   out  instruction register load
//   regdst    out  destination select: 0 = rt, 1 = rd
//   memtoreg  out  writeback select: 0 = ALUOut, 1 = MDR
//   regwrite  out  register file write
//   alusrca   out  ALU A select: 0 = PC, 1 = A reg
//   alusrcb   out  ALU B select: 00 B, 01 const 4, 10 imm, 11 imm<<2
//   aluop     out  to ALU control: 00 add, 01 sub, 10 use funct
//   pcsrc     out  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target
//   ill_op    out  unrecognised opcode, asserted in DECODE only
//   state     out  current state (debug)
// ----------------------------------------------------------------------------
module mc_control_fsm #(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic               zero,
   output logic               pcwrite,
   output logic               branch,
   output logic               pcen,
   output logic               iord,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         aluop,
   output logic [1:0]         pcsrc,
   output logic               ill_op,
   output logic [STATE_W-1:0] state
);

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
   } ctrl_t;

   state_t st;
   state_t nxt;
   ctrl_t  ctrl;

   // Control word for a given state; encodings 12..15 fall to all-zero.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'b01;
         end
         DECODE: c.alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD: c.iord = 1'b1;
         MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b10;
         end
         RTYPEWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         BEQEX: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b01;
            c.branch  = 1'b1;
            c.pcsrc   = 2'b01;
         end
         ADDIWB: c.regwrite = 1'b1;
         JEX: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = 2'b10;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = FETCH;
      case (st)
         FETCH: nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RTYPE:     nxt = RTYPEEX;
               OP_BEQ:       nxt = BEQEX;
               OP_ADDI:      nxt = ADDIEX;
               OP_J:         nxt = JEX;
               default:      nxt = FETCH;
            endcase
         end
         // IR is stable here, so op is simply sampled again.
         MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   nxt = MEMWB;
         RTYPEEX: nxt = RTYPEWB;
         ADDIEX:  nxt = ADDIWB;
         default: nxt = FETCH;
      endcase
   end

   // The control word is registered alongside the state from the next-state
   // value, so it always equals ctrl_of(st); reset loads the FETCH word
   // asynchronously, which also kills memwrite/regwrite the moment rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= FETCH;
         ctrl <= ctrl_of(FETCH);
      end else begin
         st   <= nxt;
         ctrl <= ctrl_of(nxt);
      end
   end

   assign pcwrite  = ctrl.pcwrite;
   assign branch   = ctrl.branch;
   assign iord     = ctrl.iord;
   assign memwrite = ctrl.memwrite;
   assign irwrite  = ctrl.irwrite;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign regwrite = ctrl.regwrite;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign aluop    = ctrl.aluop;
   assign pcsrc    = ctrl.pcsrc;

   // pcen follows zero within the cycle; branch is only set in BEQEX and
   // pcwrite only in FETCH/JEX, so it is 0 everywhere else.
   assign pcen = ctrl.pcwrite | (ctrl.branch & zero);

   always_comb begin
      ill_op = 1'b0;
      if (st == DECODE) begin
         case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ill_op = 1'b0;
            default:                                       ill_op = 1'b1;
         endcase
      end
   end

   assign state = STATE_W'(st);

endmodule

// File: tb/tb_mc_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Directed bench for mc_control_fsm. Walks LW, SW, RTYPE, BEQ (taken and
//   not taken), an illegal opcode and J, then resets in the middle of MEMWR.
//   Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mc_control_fsm;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       pcwrite, branch, pcen, iord, memwrite, irwrite;
   logic       regdst, memtoreg, regwrite, alusrca, ill_op;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state;

   int tests_run = 0;
   int tests_failed = 0;

   mc_control_fsm #(.STATE_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op),
      .zero     (zero),
      .pcwrite  (pcwrite),
      .branch   (branch),
      .pcen     (pcen),
      .iord     (iord),
      .memwrite (memwrite),
      .irwrite  (irwrite),
      .regdst   (regdst),
      .memtoreg (memtoreg),
      .regwrite (regwrite),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .pcsrc    (pcsrc),
      .ill_op   (ill_op),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word order:
   // pcwrite branch iord memwrite irwrite regdst memtoreg regwrite alusrca
   // alusrcb[1:0] aluop[1:0] pcsrc[1:0]
   localparam logic [14:0] C_FETCH   = 15'b100010000_01_00_00;
   localparam logic [14:0] C_DECODE  = 15'b000000000_11_00_00;
   localparam logic [14:0] C_MEMADR  = 15'b000000001_10_00_00;
   localparam logic [14:0] C_MEMRD   = 15'b001000000_00_00_00;
   localparam logic [14:0] C_MEMWB   = 15'b000000110_00_00_00;
   localparam logic [14:0] C_MEMWR   = 15'b001100000_00_00_00;
   localparam logic [14:0] C_RTYPEEX = 15'b000000001_00_10_00;
   localparam logic [14:0] C_RTYPEWB = 15'b000001010_00_00_00;
   localparam logic [14:0] C_BEQEX   = 15'b010000001_00_01_01;
   localparam logic [14:0] C_ADDIWB  = 15'b000000010_00_00_00;
   localparam logic [14:0] C_JEX     = 15'b100000000_00_00_10;

   // Reference ALU control decoder fed by aluop and funct.
   function automatic logic [2:0] aluctl(input logic [1:0] a, input logic [5:0] f);
      logic [2:0] r;
      r = 3'b010;
      if (a == 2'b01) r = 3'b110;
      else if (a[1]) begin
         case (f)
            6'b100000: r = 3'b010;
            6'b100010: r = 3'b110;
            6'b100100: r = 3'b000;
            6'b100101: r = 3'b001;
            6'b101010: r = 3'b111;
            default:   r = 3'bxxx;
         endcase
      end
      return r;
   endfunction

   // Compares {state, control word, pcen, ill_op} in one shot.
   task automatic check(input string tag, input logic [3:0] es,
                        input logic [14:0] ec, input logic ep, input logic ei);
      logic [20:0] obs, exp;
      obs = {state, pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
             regwrite, alusrca, alusrcb, aluop, pcsrc, pcen, ill_op};
      exp = {es, ec, ep, ei};
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      op    = 6'b000000;
      zero  = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("reset", 4'd0, C_FETCH, 1'b1, 1'b0);
      @(negedge clk);
      check("reset_held", 4'd0, C_FETCH, 1'b1, 1'b0);
      rst_n = 1'b1;

      // LW, zero held high to show pcen stays 0 outside FETCH/JEX/BEQEX
      op = 6'b100011; zero = 1'b1;
      check("lw_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("lw_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("lw_c3", 4'd2, C_MEMADR, 1'b0, 1'b0);
      step(); check("lw_c4", 4'd3, C_MEMRD, 1'b0, 1'b0);
      step(); check("lw_c5", 4'd4, C_MEMWB, 1'b0, 1'b0);
      zero = 1'b0;

      // SW
      step(); op = 6'b101011;
      check("sw_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("sw_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("sw_c3", 4'd2, C_MEMADR, 1'b0, 1'b0);
      step(); check("sw_c4", 4'd5, C_MEMWR, 1'b0, 1'b0);

      // RTYPE with funct = sub
      step(); op = 6'b000000;
      check("rt_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("rt_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("rt_c3", 4'd6, C_RTYPEEX, 1'b0, 1'b0);
      tests_run++;
      assert (aluctl(aluop, 6'b100010) === 3'b110)
      else begin
         tests_failed++;
         $error("FAIL rt_aluctl: observed %b expected 110", aluctl(aluop, 6'b100010));
      end
      step(); check("rt_c4", 4'd7, C_RTYPEWB, 1'b0, 1'b0);

      // BEQ taken, then zero drops mid-cycle
      step(); op = 6'b000100; zero = 1'b1;
      check("beq1_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("beq1_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("beq1_c3", 4'd8, C_BEQEX, 1'b1, 1'b0);
      zero = 1'b0;
      #1 check("beq1_zero_drop", 4'd8, C_BEQEX, 1'b0, 1'b0);

      // BEQ not taken
      step(); zero = 1'b0;
      check("beq0_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("beq0_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("beq0_c3", 4'd8, C_BEQEX, 1'b0, 1'b0);

      // Illegal opcode: two cycles
      step(); op = 6'b111111;
      check("ill_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("ill_c2", 4'd1, C_DECODE, 1'b0, 1'b1);

      // J
      step(); op = 6'b000010;
      check("j_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("j_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("j_c3", 4'd11, C_JEX, 1'b1, 1'b0);

      // ADDI
      step(); op = 6'b001000;
      check("addi_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("addi_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("addi_c3", 4'd9, C_MEMADR, 1'b0, 1'b0);
      step(); check("addi_c4", 4'd10, C_ADDIWB, 1'b0, 1'b0);

      // Reset asserted in MEMWR, released before the next rising edge
      step(); op = 6'b101011;
      check("rst_sw_c1", 4'd0, C_FETCH, 1'b1, 1'b0);
      step(); check("rst_sw_c2", 4'd1, C_DECODE, 1'b0, 1'b0);
      step(); check("rst_sw_c3", 4'd2, C_MEMADR, 1'b0, 1'b0);
      step(); check("rst_sw_c4", 4'd5, C_MEMWR, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1 check("rst_in_memwr", 4'd0, C_FETCH, 1'b1, 1'b0);
      #1 rst_n = 1'b1;
      step(); check("rst_release_decode", 4'd1, C_DECODE, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
